// File: rtl/wam_pkg.sv
// Shared whack-a-mole definitions: grid geometry, slot state encoding and position helper.
// Used by both the mole display driver and the keypad controller.
package wam_pkg;

    localparam int GRID    = 3;
    localparam int NUM_POS = GRID * GRID;
    localparam int POS_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PEND
    } slot_state_e;

    function automatic logic [POS_W-1:0] pos(input logic [1:0] row, input logic [1:0] col);
        return POS_W'(GRID * int'(row) + int'(col));
    endfunction

endpackage

// File: rtl/led_scan_mux.sv
// Column scanner for the 3x3 mole matrix: walks columns every SCAN_DIV clocks and
// registers the active-low row/column drive from a 9-bit position map.
module led_scan_mux
    import wam_pkg::*;
#(
    parameter int SCAN_DIV = 16667
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_POS-1:0] map,
    output logic [GRID-1:0]    led_row,
    output logic [GRID-1:0]    led_col
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       col;
    logic [GRID-1:0]  row_next;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        row_next = '1;
        for (int r = 0; r < GRID; r++) begin
            row_next[r] = ~map[pos(2'(r), col)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            col      <= '0;
            led_col  <= 3'b110;
            led_row  <= '1;
        end else begin
            if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                col      <= (col == 2'(GRID - 1)) ? 2'd0 : col + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            led_col <= ~(GRID'(1) << col);
            led_row <= row_next;
        end
    end

endmodule

// File: rtl/mole_display_driver.sv
// Whack-a-mole LED side: per-position mole slots with lifetime timers, hit/miss reporting
// and a scanned 3x3 matrix. Define MOLE_BLINK_EN to blink moles in their last quarter of life.
module mole_display_driver
    import wam_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SCAN_DIV = 16667,
    parameter int LIFE_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [POS_W-1:0]   spawn_pos,
    input  logic [LIFE_W-1:0]  spawn_life,
    input  logic               whack_valid,
    input  logic [POS_W-1:0]   whack_pos,
    output logic               hit,
    output logic               miss,
    output logic [POS_W-1:0]   event_pos,
    output logic [NUM_POS-1:0] active,
    output logic [GRID-1:0]    led_row,
    output logic [GRID-1:0]    led_col
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    slot_state_e        state [NUM_POS];
    logic [LIFE_W-1:0]  timer [NUM_POS];
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [NUM_POS-1:0] spawn_sel;
    logic [NUM_POS-1:0] whack_sel;
    logic [NUM_POS-1:0] led_map;
    logic               hit_now;
    logic               spawn_fire;
    logic               miss_found;
    logic [POS_W-1:0]   miss_idx;
    logic [LIFE_W-1:0]  life_load;

    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign life_load = (spawn_life == '0) ? LIFE_W'(1) : spawn_life;

    always_comb begin
        spawn_sel  = '0;
        whack_sel  = '0;
        active     = '0;
        miss_found = 1'b0;
        miss_idx   = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            spawn_sel[i] = (spawn_pos == POS_W'(i)) && (state[i] == IDLE);
            whack_sel[i] = whack_valid && (whack_pos == POS_W'(i)) && (state[i] == ACTIVE);
            active[i]    = (state[i] == ACTIVE);
        end
        // Descending scan leaves the lowest pending index selected.
        for (int i = NUM_POS - 1; i >= 0; i--) begin
            if (state[i] == PEND) begin
                miss_found = 1'b1;
                miss_idx   = POS_W'(i);
            end
        end
        hit_now     = |whack_sel;
        spawn_ready = |spawn_sel;
        spawn_fire  = spawn_valid && spawn_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            event_pos <= '0;
            // NOTE: the slot arrays are small control state, so they are reset like any register.
            for (int i = 0; i < NUM_POS; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            hit      <= hit_now;
            miss     <= !hit_now && miss_found;
            if (hit_now) begin
                event_pos <= whack_pos;
            end else if (miss_found) begin
                event_pos <= miss_idx;
            end
            for (int i = 0; i < NUM_POS; i++) begin
                case (state[i])
                    IDLE: begin
                        if (spawn_fire && spawn_sel[i]) begin
                            state[i] <= ACTIVE;
                            timer[i] <= life_load;
                        end
                    end
                    ACTIVE: begin
                        // A whack landing on the expiry tick still counts as a hit.
                        if (whack_sel[i]) begin
                            state[i] <= IDLE;
                            timer[i] <= '0;
                        end else if (tick) begin
                            timer[i] <= timer[i] - LIFE_W'(1);
                            if (timer[i] == LIFE_W'(1)) begin
                                state[i] <= PEND;
                            end
                        end
                    end
                    PEND: begin
                        if (!hit_now && miss_found && (miss_idx == POS_W'(i))) begin
                            state[i] <= IDLE;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

`ifdef MOLE_BLINK_EN
    logic [LIFE_W-1:0] threshold [NUM_POS];
    logic [7:0]        blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            for (int i = 0; i < NUM_POS; i++) begin
                threshold[i] <= '0;
            end
        end else begin
            if (tick) begin
                blink_cnt <= blink_cnt + 8'd1;
            end
            for (int i = 0; i < NUM_POS; i++) begin
                if (spawn_fire && spawn_sel[i]) begin
                    threshold[i] <= spawn_life >> 2;
                end
            end
        end
    end

    // Bit 7 of the tick count flips every 128 ticks; the LED is dark in phase 1.
    always_comb begin
        led_map = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            led_map[i] = active[i] && !((timer[i] < threshold[i]) && blink_cnt[7]);
        end
    end
`else
    assign led_map = active;
`endif

    led_scan_mux #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .map     (led_map),
        .led_row (led_row),
        .led_col (led_col)
    );

endmodule

// File: tb/tb_mole_display_driver.sv
// Scoreboard bench for mole_display_driver: a behavioural model predicts hit/miss events,
// the active bitmap and the scanned LED drive; a monitor compares on every falling edge.
module tb_mole_display_driver;

    localparam int TICK_DIV = 20;
    localparam int SCAN_DIV = 8;
    localparam int LIFE_W   = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              spawn_valid = 1'b0;
    logic              spawn_ready;
    logic [3:0]        spawn_pos = '0;
    logic [LIFE_W-1:0] spawn_life = '0;
    logic              whack_valid = 1'b0;
    logic [3:0]        whack_pos = '0;
    logic              hit;
    logic              miss;
    logic [3:0]        event_pos;
    logic [8:0]        active;
    logic [2:0]        led_row;
    logic [2:0]        led_col;

    int checks = 0;
    int errors = 0;

    mole_display_driver #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .LIFE_W   (LIFE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_pos   (spawn_pos),
        .spawn_life  (spawn_life),
        .whack_valid (whack_valid),
        .whack_pos   (whack_pos),
        .hit         (hit),
        .miss        (miss),
        .event_pos   (event_pos),
        .active      (active),
        .led_row     (led_row),
        .led_col     (led_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit is_hit;
        int pos;
    } ev_t;

    ev_t        exp_q[$];
    int         life_left [9];   // ticks remaining; 0 = no live mole
    bit         waiting   [9];   // expired, miss not yet reported
    int         edge_idx;        // clock edges since reset release
    logic [8:0] prev_active;
    logic [3:0] last_pos;

    function automatic logic [8:0] model_active();
        logic [8:0] a;
        a = '0;
        for (int p = 0; p < 9; p++) a[p] = (life_left[p] > 0);
        return a;
    endfunction

    function automatic bit model_ready(input int p);
        if (p > 8) return 1'b0;
        return (life_left[p] == 0) && !waiting[p];
    endfunction

    always @(posedge clk or posedge reset) begin : model_step
        bit spawn_ok;
        bit tick;
        int sp;
        int wp;
        int lowest;
        if (reset) begin
            for (int p = 0; p < 9; p++) begin
                life_left[p] = 0;
                waiting[p]   = 1'b0;
            end
            edge_idx    = 0;
            prev_active = '0;
            last_pos    = '0;
            exp_q.delete();
        end else begin
            sp = int'(spawn_pos);
            wp = int'(whack_pos);
            spawn_ok    = spawn_valid && model_ready(sp);
            prev_active = model_active();
            if (whack_valid && wp < 9 && life_left[wp] > 0) begin
                life_left[wp] = 0;
                exp_q.push_back('{1'b1, wp});
                last_pos = 4'(wp);
            end else begin
                lowest = -1;
                for (int p = 8; p >= 0; p--) if (waiting[p]) lowest = p;
                if (lowest >= 0) begin
                    waiting[lowest] = 1'b0;
                    exp_q.push_back('{1'b0, lowest});
                    last_pos = 4'(lowest);
                end
            end
            tick = (edge_idx % TICK_DIV) == TICK_DIV - 1;
            edge_idx++;
            if (tick) begin
                for (int p = 0; p < 9; p++) begin
                    if (life_left[p] > 0) begin
                        life_left[p]--;
                        if (life_left[p] == 0) waiting[p] = 1'b1;
                    end
                end
            end
            if (spawn_ok) life_left[sp] = (spawn_life == 0) ? 1 : int'(spawn_life);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        ev_t        ev;
        int         c;
        logic [2:0] exp_col;
        logic [2:0] exp_row;
        if (!reset) begin
            if (hit || miss) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, hit, miss}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", {30'd0, hit, miss}, ev.is_hit ? 32'd2 : 32'd1);
                    check("event_pos", event_pos, ev.pos);
                end
            end else if (exp_q.size() != 0) begin
                ev = exp_q.pop_front();
                check("missing_event", {30'd0, hit, miss}, ev.is_hit ? 32'd2 : 32'd1);
            end
            check("active", active, model_active());
            check("event_pos_hold", event_pos, last_pos);
            check("spawn_ready", spawn_ready, model_ready(int'(spawn_pos)));
`ifndef MOLE_BLINK_EN
            if (edge_idx == 0) begin
                exp_col = 3'b110;
                exp_row = 3'b111;
            end else begin
                c       = ((edge_idx - 1) / SCAN_DIV) % 3;
                exp_col = ~(3'b001 << c);
                for (int r = 0; r < 3; r++) exp_row[r] = ~prev_active[3 * r + c];
            end
            check("led_col", led_col, exp_col);
            check("led_row", led_row, exp_row);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic spawn(input int p, input int life);
        spawn_pos   = 4'(p);
        spawn_life  = LIFE_W'(life);
        spawn_valid = 1'b1;
        #1;
        check("spawn_accept", spawn_ready, 1);
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic wait_event(input bit want_hit, input int p, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (hit || miss) break;
        end
        check("event_seen", hit | miss, 1);
        check("event_is_hit", hit, want_hit);
        check("event_at", event_pos, p);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (hit || miss) n++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bit [2:0] seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        check("rst_event_pos", event_pos, 0);
        check("rst_active", active, 0);
        check("rst_led_col", led_col, 3'b110);
        check("rst_led_row", led_row, 3'b111);
        reset = 1'b0;
        step();

        // Spawn pos 4, life 3 -> miss at pos 4
        spawn(4, 3);
        check("s1_active", active, 9'h010);
        wait_event(1'b0, 4, 5 * TICK_DIV);
        step();
        check("s1_cleared", active, 0);

        // Spawn pos 0, whack one clock later -> hit, never a miss
        spawn(0, 50);
        whack_pos   = 4'd0;
        whack_valid = 1'b1;
        step();
        whack_valid = 1'b0;
        check("s2_hit", hit, 1);
        check("s2_pos", event_pos, 0);
        count_pulses(3 * TICK_DIV, n);
        check("s2_no_miss", n, 0);

        // Spawn 2 and 6 inside one tick window -> ordered misses
        for (int k = 0; k < TICK_DIV && (edge_idx % TICK_DIV) != 2; k++) step();
        spawn(2, 2);
        spawn(6, 2);
        wait_event(1'b0, 2, 4 * TICK_DIV);
        spawn_pos = 4'd6;
        #1;
        check("s3_ready6_low", spawn_ready, 0);
        step();
        check("s3_miss6", miss, 1);
        check("s3_pos6", event_pos, 6);
        check("s3_ready6_high", spawn_ready, 1);

        // Whack on the expiry tick edge -> hit only
        for (int k = 0; k < TICK_DIV && (edge_idx % TICK_DIV) != 1; k++) step();
        spawn(5, 1);
        for (int k = 0; k < TICK_DIV && (edge_idx % TICK_DIV) != TICK_DIV - 1; k++) step();
        whack_pos   = 4'd5;
        whack_valid = 1'b1;
        step();
        whack_valid = 1'b0;
        check("s4_hit", hit, 1);
        check("s4_no_miss", miss, 0);
        check("s4_pos", event_pos, 5);
        count_pulses(2 * TICK_DIV, n);
        check("s4_no_late_miss", n, 0);

        // Out-of-range and idle whacks, out-of-range spawn, zero lifetime
        whack_pos   = 4'd9;
        whack_valid = 1'b1;
        step();
        check("whack9_ignored", hit | miss, 0);
        whack_pos = 4'd3;
        step();
        whack_valid = 1'b0;
        check("whack_idle_ignored", hit | miss, 0);
        spawn_pos = 4'd9;
        #1;
        check("spawn9_not_ready", spawn_ready, 0);
        spawn(7, 0);
        wait_event(1'b0, 7, 3 * TICK_DIV);

        // Diagonal pattern over three scan periods
        spawn(0, 300);
        spawn(4, 300);
        spawn(8, 300);
        step();
        step();
        seen = '0;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            step();
            case (led_col)
                3'b110: begin seen[0] = 1'b1; check("diag_col0", led_row, 3'b110); end
                3'b101: begin seen[1] = 1'b1; check("diag_col1", led_row, 3'b101); end
                3'b011: begin seen[2] = 1'b1; check("diag_col2", led_row, 3'b011); end
                default: check("diag_col_valid", led_col, 3'b110);
            endcase
        end
        check("diag_all_cols", seen, 3'b111);

        // Reset with three live moles and a pending miss
        spawn(1, 1);
        for (int k = 0; k < 3 * TICK_DIV && !waiting[1]; k++) step();
        check("s6_pending", waiting[1], 1);
        reset = 1'b1;
        #1;
        check("s6_hit", hit, 0);
        check("s6_miss", miss, 0);
        check("s6_event_pos", event_pos, 0);
        check("s6_active", active, 0);
        check("s6_led_col", led_col, 3'b110);
        check("s6_led_row", led_row, 3'b111);
        step();
        step();
        reset = 1'b0;
        count_pulses(3 * TICK_DIV, n);
        check("s6_no_pulse", n, 0);
        check("s6_active_after", active, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            spawn_valid = ($urandom_range(0, 2) == 0);
            spawn_pos   = 4'($urandom_range(0, 10));
            spawn_life  = LIFE_W'($urandom_range(0, 5));
            whack_valid = ($urandom_range(0, 3) == 0);
            whack_pos   = 4'($urandom_range(0, 10));
            step();
        end
        spawn_valid = 1'b0;
        whack_valid = 1'b0;
        repeat (10 * TICK_DIV) step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
